// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master) and imem (slave).
interface if_stage_if;
  logic        imem_req;
  logic [0:15] imem_addr;
  logic        imem_ack;
  logic [0:31] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and drives the IF/ID
// pipeline register, absorbing hazard stalls and squashing wrong-path fetches on branches.
module if_stage #(
  parameter logic [0:15] RESET_PC = 16'h0000,
  parameter logic [0:15] PC_INC   = 16'd4,
  parameter logic [0:31] NOP_INST = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         ID_br_ctrl,
  input  logic [0:15]  ID_br_pc,
  if_stage_if.master   imem,
  output logic [0:31]  ID_inst,
  output logic [0:15]  ID_pc,
  output logic         ID_valid
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [0:15] pc_q, pc_d;
  logic [0:15] tgt_q, tgt_d;
  logic [0:31] buf_inst_q, buf_inst_d;
  logic [0:15] buf_pc_q, buf_pc_d;
  logic [0:31] id_inst_q, id_inst_d;
  logic [0:15] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;

  logic req;
  logic acc;
  logic br_take;
  logic bubble;

  assign req     = (state_q == StFetch) || (state_q == StDiscard);
  // Data is only accepted for a request actually on the bus; a stray ack is ignored.
  assign acc     = req && imem.imem_ack;
  assign br_take = ID_br_ctrl && !stall;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign ID_inst        = id_inst_q;
  assign ID_pc          = id_pc_q;
  assign ID_valid       = id_valid_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    bubble     = 1'b0;

    case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        if (br_take) begin
          bubble = 1'b1;
          if (acc) begin
            pc_d = ID_br_pc;
          end else begin
            // Keep the address stable until the in-flight request completes.
            tgt_d   = ID_br_pc;
            state_d = StDiscard;
          end
        end else if (stall) begin
          if (acc) begin
            buf_inst_d = imem.imem_rdata;
            buf_pc_d   = pc_q;
            pc_d       = pc_q + PC_INC;
            state_d    = StHold;
          end
        end else if (acc) begin
          id_inst_d  = imem.imem_rdata;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_q + PC_INC;
        end else begin
          bubble = 1'b1;
        end
      end

      StHold: begin
        if (br_take) begin
          bubble  = 1'b1;
          pc_d    = ID_br_pc;
          state_d = StFetch;
        end else if (!stall) begin
          id_inst_d  = buf_inst_q;
          id_pc_d    = buf_pc_q;
          id_valid_d = 1'b1;
          state_d    = StFetch;
        end
      end

      StDiscard: begin
        // Decode holds only bubbles here, so a further branch cannot be meaningful.
        if (acc) begin
          pc_d    = tgt_q;
          state_d = StFetch;
        end
        if (!stall) begin
          bubble = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    if (bubble) begin
      id_inst_d  = NOP_INST;
      id_pc_d    = '0;
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      buf_inst_q <= '0;
      buf_pc_q   <= '0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

endmodule
